// File: rtl/storage_arb_pkg.sv
// -----------------------------------------------------------------------------
// storage_arb_pkg
// Shared definitions for the storage arbiter slice: FSM state encoding,
// default request-word field widths and the storage response layout
// ({number[3:0], data[31:0]} with the tag in bits [35:32]).
// -----------------------------------------------------------------------------
package storage_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int NUM_W_DEF  = 4;
   localparam int ADDR_W_DEF = 8;
   localparam int REQ_WORD_W = NUM_W_DEF + ADDR_W_DEF;

   localparam int RSP_W  = 36;
   localparam int TAG_HI = 35;
   localparam int TAG_LO = 32;

endpackage

// File: rtl/storage_req_fifo.sv
// -----------------------------------------------------------------------------
// storage_req_fifo
// Synchronous first-word-fall-through FIFO holding {number, addr} request
// words on their way to the storage command channel.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   push, din   : write strobe and data
//   pop         : read strobe (ignored when empty)
//   dout        : head entry, valid whenever !empty
//   empty, full : status decoded from the occupancy counter
// -----------------------------------------------------------------------------
module storage_req_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             pop_ok;

   assign pop_ok = pop & ~empty;

   // Storage array carries no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/storage_arbiter.sv
// -----------------------------------------------------------------------------
// storage_arbiter
// Round-robin arbiter sharing one storage port among N_REQ storage_control
// cores. One core is granted at a time (one-hot grant); its {number, addr}
// word is pushed into a request FIFO presented to storage over valid/ready.
// Storage responses are registered and broadcast to all cores.
// Optional feature macro: STORAGE_ARB_TIMEOUT_EN -- revokes a grant after
// TIMEOUT cycles without the granted core's strobe and pulses timeout_err.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   req                : per-core request (bit i = core number i+1)
//   storage_valid      : per-core write strobe, only the granted bit counts
//   number_and_addr    : packed per-core {number, addr} words
//   grant              : one-hot grant, 0 when idle
//   cmd_valid/cmd_data : FIFO head (fall-through), cmd_ready pops it
//   rsp_valid/rsp_data : storage response input
//   txn_done           : registered rsp_valid
//   data_from_storage  : registered rsp_data, loaded on rsp_valid
//   tag_err            : pulse when the pushed tag differs from idx+1
//   timeout_err        : pulse on grant revoke (0 without the macro)
// -----------------------------------------------------------------------------
module storage_arbiter
   import storage_arb_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int NUM_W      = NUM_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [N_REQ-1:0]                 req,
   input  logic [N_REQ-1:0]                 storage_valid,
   input  logic [N_REQ*(NUM_W+ADDR_W)-1:0]  number_and_addr,
   output logic [N_REQ-1:0]                 grant,
   output logic                             cmd_valid,
   output logic [NUM_W+ADDR_W-1:0]          cmd_data,
   input  logic                             cmd_ready,
   input  logic                             rsp_valid,
   input  logic [RSP_W-1:0]                 rsp_data,
   output logic                             txn_done,
   output logic [RSP_W-1:0]                 data_from_storage,
   output logic                             tag_err,
   output logic                             timeout_err
);

   localparam int WORD_W = NUM_W + ADDR_W;
   localparam int PTR_W  = $clog2(N_REQ);

   arb_state_e         state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   idx_q, idx_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic               tag_err_q, tag_err_d;
   logic               txn_done_q;
   logic [RSP_W-1:0]   rsp_data_q;

   logic               found;
   logic [PTR_W-1:0]   pick;
   logic [PTR_W-1:0]   cand;
   logic [PTR_W-1:0]   idx_next;
   logic [WORD_W-1:0]  push_word;
   logic               push;
   logic               pop;
   logic               fifo_empty;
   logic               fifo_full;

   // Round-robin search: first requesting core at or after ptr_q, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = PTR_W'((int'(ptr_q) + k) % N_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign idx_next  = PTR_W'((int'(idx_q) + 1) % N_REQ);
   assign push_word = number_and_addr[int'(idx_q)*WORD_W +: WORD_W];

`ifdef STORAGE_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt_q;
   logic             timeout_err_q, timeout_err_d;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      grant_d   = grant_q;
      tag_err_d = 1'b0;
      push      = 1'b0;
`ifdef STORAGE_ARB_TIMEOUT_EN
      timeout_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            grant_d = '0;
            // Only one grant is ever outstanding, so "not full" here
            // guarantees room for the push that ends this grant.
            if (found && !fifo_full) begin
               idx_d   = pick;
               grant_d = N_REQ'(1) << pick;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (storage_valid[idx_q]) begin
               push      = 1'b1;
               grant_d   = '0;
               ptr_d     = idx_next;
               state_d   = IDLE;
               tag_err_d = (push_word[WORD_W-1 -: NUM_W] != NUM_W'(int'(idx_q) + 1));
            end
`ifdef STORAGE_ARB_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
               grant_d       = '0;
               ptr_d         = idx_next;
               state_d       = IDLE;
               timeout_err_d = 1'b1;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         idx_q     <= '0;
         grant_q   <= '0;
         tag_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         grant_q   <= grant_d;
         tag_err_q <= tag_err_d;
      end
   end

`ifdef STORAGE_ARB_TIMEOUT_EN
   // Counts cycles spent in the current grant; cleared whenever a grant ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         tmo_cnt_q     <= (state_q == GRANT && state_d == GRANT) ? tmo_cnt_q + 1'b1 : '0;
         timeout_err_q <= timeout_err_d;
      end
   end
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   // Response path is a plain register stage, independent of arbitration.
   always_ff @(posedge clk) begin
      if (rst) begin
         txn_done_q <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         txn_done_q <= rsp_valid;
         if (rsp_valid) begin
            rsp_data_q <= rsp_data;
         end
      end
   end

   assign pop = cmd_valid & cmd_ready;

   storage_req_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_word),
      .dout  (cmd_data),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign grant             = grant_q;
   assign cmd_valid         = ~fifo_empty;
   assign tag_err           = tag_err_q;
   assign txn_done          = txn_done_q;
   assign data_from_storage = rsp_data_q;

endmodule

// File: tb/tb_storage_arbiter.sv
module tb_storage_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [3:0]  storage_valid = '0;
   logic [47:0] number_and_addr = '0;
   logic [3:0]  grant;
   logic        cmd_valid;
   logic [11:0] cmd_data;
   logic        cmd_ready = 1'b0;
   logic        rsp_valid = 1'b0;
   logic [35:0] rsp_data = '0;
   logic        txn_done;
   logic [35:0] data_from_storage;
   logic        tag_err;
   logic        timeout_err;

   int tests_run = 0;
   int tests_failed = 0;

   storage_arbiter dut (
      .clk               (clk),
      .rst               (rst),
      .req               (req),
      .storage_valid     (storage_valid),
      .number_and_addr   (number_and_addr),
      .grant             (grant),
      .cmd_valid         (cmd_valid),
      .cmd_data          (cmd_data),
      .cmd_ready         (cmd_ready),
      .rsp_valid         (rsp_valid),
      .rsp_data          (rsp_data),
      .txn_done          (txn_done),
      .data_from_storage (data_from_storage),
      .tag_err           (tag_err),
      .timeout_err       (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Canonical words: core i carries tag i+1 and address 0x10+i.
   task automatic set_canonical_words;
      for (int i = 0; i < 4; i++) begin
         number_and_addr[i*12 +: 12] = {4'(i + 1), 8'(8'h10 + i)};
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant: got %b expected 0000", grant); end
      tests_run++; if (cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
      tests_run++; if (txn_done !== 1'b0) begin tests_failed++; $display("FAIL reset_txn_done: got %b expected 0", txn_done); end
      tests_run++; if (data_from_storage !== 36'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", data_from_storage); end
      tests_run++; if (tag_err !== 1'b0) begin tests_failed++; $display("FAIL reset_tag_err: got %b expected 0", tag_err); end
      tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
      rst = 1'b0;
      $display("[TB] reset done");
   endtask

   task automatic test_round_robin;
      logic [3:0]  exp_g;
      logic [11:0] exp_w;
      set_canonical_words;
      cmd_ready = 1'b1;
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         exp_g = 4'b0001 << (i % 4);
         exp_w = {4'((i % 4) + 1), 8'(8'h10 + (i % 4))};
         tick;  // E0
         tests_run++; if (grant !== exp_g) begin tests_failed++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, grant, exp_g); end
         tick;  // E1
         storage_valid = exp_g;
         tick;  // E2
         storage_valid = '0;
         tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL rr_release[%0d]: got %b expected 0000", i, grant); end
         tests_run++; if (cmd_valid !== 1'b1 || cmd_data !== exp_w) begin tests_failed++; $display("FAIL rr_push[%0d]: got v=%b d=%h expected v=1 d=%h", i, cmd_valid, cmd_data, exp_w); end
         tests_run++; if (tag_err !== 1'b0) begin tests_failed++; $display("FAIL rr_tag_err[%0d]: got %b expected 0", i, tag_err); end
         $display("[TB] rr grant %b pushed %h", exp_g, exp_w);
      end
      req = '0;
      tick;
   endtask

   task automatic test_single;
      number_and_addr[2*12 +: 12] = 12'h33C;
      req = 4'b0100;
      tick;  // E0
      tests_run++; if (grant !== 4'b0100) begin tests_failed++; $display("FAIL single_grant: got %b expected 0100", grant); end
      tick;  // E1
      tests_run++; if (grant !== 4'b0100) begin tests_failed++; $display("FAIL single_hold: got %b expected 0100", grant); end
      storage_valid = 4'b0100;
      req = '0;
      tick;  // E2
      storage_valid = '0;
      tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL single_release: got %b expected 0000", grant); end
      tests_run++; if (cmd_valid !== 1'b1 || cmd_data !== 12'h33C) begin tests_failed++; $display("FAIL single_push: got v=%b d=%h expected v=1 d=33c", cmd_valid, cmd_data); end
      tick;  // E3, popped
      tests_run++; if (cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL single_pop: got %b expected 0", cmd_valid); end
      $display("[TB] single core 2 pushed 33c");
      // ptr is now 3: with cores 0 and 3 requesting, core 3 wins.
      number_and_addr[0 +: 12]    = 12'h1AA;
      number_and_addr[3*12 +: 12] = 12'h4BB;
      req = 4'b1001;
      tick;
      tests_run++; if (grant !== 4'b1000) begin tests_failed++; $display("FAIL single_ptr: got %b expected 1000", grant); end
      tick;
      storage_valid = 4'b1000;
      req = '0;
      tick;
      storage_valid = '0;
      tests_run++; if (cmd_data !== 12'h4BB) begin tests_failed++; $display("FAIL single_ptr_push: got %h expected 4bb", cmd_data); end
      tick;
   endtask

   task automatic test_fifo_full;
      logic [11:0] exp_q [4];
      set_canonical_words;
      cmd_ready = 1'b0;
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         tick;
         tests_run++; if (grant !== (4'b0001 << i)) begin tests_failed++; $display("FAIL full_fill_grant[%0d]: got %b expected %b", i, grant, 4'b0001 << i); end
         tick;
         storage_valid = grant;
         tick;
         storage_valid = '0;
      end
      tick;
      tick;
      tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL full_block: got %b expected 0000", grant); end
      tests_run++; if (cmd_data !== 12'h110) begin tests_failed++; $display("FAIL full_head: got %h expected 110", cmd_data); end
      cmd_ready = 1'b1;
      tick;  // pop; full still seen at this IDLE sample
      cmd_ready = 1'b0;
      tests_run++; if (grant !== 4'b0000 || cmd_data !== 12'h211) begin tests_failed++; $display("FAIL full_pop: got g=%b d=%h expected g=0000 d=211", grant, cmd_data); end
      tick;
      tests_run++; if (grant !== 4'b0001) begin tests_failed++; $display("FAIL full_regrant: got %b expected 0001", grant); end
      tick;
      storage_valid = 4'b0001;
      req = '0;
      tick;
      storage_valid = '0;
      exp_q[0] = 12'h211; exp_q[1] = 12'h312; exp_q[2] = 12'h413; exp_q[3] = 12'h110;
      cmd_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         tests_run++; if (cmd_valid !== 1'b1 || cmd_data !== exp_q[j]) begin tests_failed++; $display("FAIL full_drain[%0d]: got v=%b d=%h expected v=1 d=%h", j, cmd_valid, cmd_data, exp_q[j]); end
         $display("[TB] drain entry %0d = %h", j, cmd_data);
         tick;
      end
      tests_run++; if (cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL full_empty: got %b expected 0", cmd_valid); end
   endtask

   task automatic test_tag_err;
      number_and_addr[0 +: 12] = 12'h255;
      req = 4'b0001;
      tick;
      tests_run++; if (grant !== 4'b0001) begin tests_failed++; $display("FAIL tag_grant: got %b expected 0001", grant); end
      tick;
      storage_valid = 4'b0001;
      req = '0;
      tick;
      storage_valid = '0;
      tests_run++; if (tag_err !== 1'b1) begin tests_failed++; $display("FAIL tag_pulse: got %b expected 1", tag_err); end
      tests_run++; if (cmd_valid !== 1'b1 || cmd_data !== 12'h255) begin tests_failed++; $display("FAIL tag_push: got v=%b d=%h expected v=1 d=255", cmd_valid, cmd_data); end
      tick;
      tests_run++; if (tag_err !== 1'b0) begin tests_failed++; $display("FAIL tag_one_cycle: got %b expected 0", tag_err); end
      $display("[TB] tag mismatch core 0 pushed 255");
      set_canonical_words;
   endtask

   task automatic test_timeout;
      int held;
      req = 4'b0110;
      tick;
      tests_run++; if (grant !== 4'b0010) begin tests_failed++; $display("FAIL tmo_grant: got %b expected 0010", grant); end
`ifdef STORAGE_ARB_TIMEOUT_EN
      for (int k = 0; k < 15; k++) tick;
      tests_run++; if (grant !== 4'b0010) begin tests_failed++; $display("FAIL tmo_held16: got %b expected 0010", grant); end
      tick;
      tests_run++; if (grant !== 4'b0000 || timeout_err !== 1'b1) begin tests_failed++; $display("FAIL tmo_revoke: got g=%b te=%b expected g=0000 te=1", grant, timeout_err); end
      tests_run++; if (cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL tmo_no_push: got %b expected 0", cmd_valid); end
      tick;
      tests_run++; if (grant !== 4'b0100 || timeout_err !== 1'b0) begin tests_failed++; $display("FAIL tmo_next: got g=%b te=%b expected g=0100 te=0", grant, timeout_err); end
      req = '0;
      tick;
      storage_valid = 4'b0100;
`else
      held = 0;
      for (int k = 0; k < 100; k++) begin
         tick;
         if (grant === 4'b0010 && timeout_err === 1'b0) held++;
      end
      tests_run++; if (held !== 100) begin tests_failed++; $display("FAIL tmo_hold: got %0d held cycles expected 100", held); end
      req = '0;
      storage_valid = 4'b0010;
`endif
      tick;
      storage_valid = '0;
      tick;
      $display("[TB] timeout scenario done");
   endtask

   task automatic test_response;
      rsp_valid = 1'b1;
      rsp_data  = 36'h3DEADBEEF;
      tick;
      rsp_valid = 1'b0;
      rsp_data  = 36'h112345678;
      tests_run++; if (txn_done !== 1'b1) begin tests_failed++; $display("FAIL rsp_done: got %b expected 1", txn_done); end
      tests_run++; if (data_from_storage !== 36'h3DEADBEEF) begin tests_failed++; $display("FAIL rsp_data: got %h expected 3deadbeef", data_from_storage); end
      tick;
      tests_run++; if (txn_done !== 1'b0) begin tests_failed++; $display("FAIL rsp_done_clear: got %b expected 0", txn_done); end
      tests_run++; if (data_from_storage !== 36'h3DEADBEEF) begin tests_failed++; $display("FAIL rsp_hold: got %h expected 3deadbeef", data_from_storage); end
      $display("[TB] response 3deadbeef");
   endtask

   task automatic test_reset_mid;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      cmd_ready = 1'b0;
      req = 4'b0011;
      tick;
      tick;
      storage_valid = 4'b0001;
      tick;
      storage_valid = '0;
      tick;
      tests_run++; if (grant !== 4'b0010) begin tests_failed++; $display("FAIL mid_second_grant: got %b expected 0010", grant); end
      tick;
      storage_valid = 4'b0010;
      req = 4'b0100;
      tick;
      storage_valid = '0;
      tick;
      tests_run++; if (grant !== 4'b0100 || cmd_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_setup: got g=%b v=%b expected g=0100 v=1", grant, cmd_valid); end
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL mid_grant: got %b expected 0000", grant); end
      tests_run++; if (cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_cmd_valid: got %b expected 0", cmd_valid); end
      tests_run++; if (data_from_storage !== 36'h0) begin tests_failed++; $display("FAIL mid_data: got %h expected 0", data_from_storage); end
      req = 4'b1111;
      tick;
      tests_run++; if (grant !== 4'b0001) begin tests_failed++; $display("FAIL mid_ptr_reset: got %b expected 0001", grant); end
      req = '0;
      $display("[TB] reset mid-grant done");
   endtask

   initial begin
      test_reset;
      test_round_robin;
      test_single;
      test_fifo_full;
      test_tag_err;
      test_timeout;
      test_response;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
